// File: rtl/shift_seq_if.sv
// Request/response bundle between the execute stage and the shift sequencer.
// The master issues shift requests and acknowledges results; the slave runs them.
interface shift_seq_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) ();
    logic             start;
    logic [WIDTH-1:0] in;
    logic [2:0]       op;
    logic [CNT_W-1:0] cnt;
    logic             ack;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    modport master (
        output start, in, op, cnt, ack,
        input  busy, done, err, result
    );

    modport slave (
        input  start, in, op, cnt, ack,
        output busy, done, err, result
    );
endinterface

// File: rtl/shift_seq.sv
// Iterative shift/rotate unit: applies one single-bit step per clock, cnt times,
// then holds the result with done until the consumer acknowledges it.
module shift_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input logic        clk,
    input logic        rst,
    shift_seq_if.slave sq
);

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_ROR = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seqState_e;

    seqState_e        state_q, state_d;
    logic [WIDTH-1:0] shiftVal_q, shiftVal_d;
    logic [2:0]       opSel_q, opSel_d;
    logic [CNT_W-1:0] stepsLeft_q, stepsLeft_d;
    logic             errFlag_q, errFlag_d;
    logic             busyFlag_q;
    logic             doneFlag_q;
    logic             acceptReq;

    function automatic logic [WIDTH-1:0] stepFn(input logic [2:0] opc, input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] y;
        y = x;
        case (opc)
            OP_ROL:  y = {x[WIDTH-2:0], x[WIDTH-1]};
            OP_ROR:  y = {x[0], x[WIDTH-1:1]};
            OP_SLL:  y = {x[WIDTH-2:0], 1'b0};
            OP_SRA:  y = {x[WIDTH-1], x[WIDTH-1:1]};
            OP_SRL:  y = {1'b0, x[WIDTH-1:1]};
            default: y = x;
        endcase
        return y;
    endfunction

    always_comb begin
        state_d     = state_q;
        shiftVal_d  = shiftVal_q;
        opSel_d     = opSel_q;
        stepsLeft_d = stepsLeft_q;
        errFlag_d   = errFlag_q;
        acceptReq   = 1'b0;

        case (state_q)
            IDLE: begin
                acceptReq = sq.start;
            end
            SHIFT: begin
                if (stepsLeft_q != '0) begin
                    shiftVal_d  = stepFn(opSel_q, shiftVal_q);
                    stepsLeft_d = stepsLeft_q - 1'b1;
                end else begin
                    state_d   = DONE;
                    errFlag_d = 1'b0;
                end
            end
            DONE: begin
                if (sq.ack) begin
                    state_d   = IDLE;
                    errFlag_d = 1'b0;
                    acceptReq = sq.start;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A DONE-state ack with start takes the new request on the same edge.
        if (acceptReq) begin
            shiftVal_d = sq.in;
            if (sq.op <= OP_SRL) begin
                opSel_d     = sq.op;
                stepsLeft_d = sq.cnt;
                errFlag_d   = 1'b0;
                state_d     = SHIFT;
            end else begin
                errFlag_d = 1'b1;
                state_d   = DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shiftVal_q  <= '0;
            opSel_q     <= OP_ROL;
            stepsLeft_q <= '0;
            errFlag_q   <= 1'b0;
            busyFlag_q  <= 1'b0;
            doneFlag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shiftVal_q  <= shiftVal_d;
            opSel_q     <= opSel_d;
            stepsLeft_q <= stepsLeft_d;
            errFlag_q   <= errFlag_d;
            busyFlag_q  <= (state_d == SHIFT);
            doneFlag_q  <= (state_d == DONE);
        end
    end

    assign sq.busy   = busyFlag_q;
    assign sq.done   = doneFlag_q;
    assign sq.err    = errFlag_q;
    assign sq.result = shiftVal_q;

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq: each task drives one scenario and compares
// against hand-computed results, sampling on the falling clock edge.
module tb_shift_seq;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    shift_seq_if #(.WIDTH(16), .CNT_W(4)) sq ();

    shift_seq #(.WIDTH(16), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .sq  (sq.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents a request on one rising edge (edge k); returns at the falling edge after it.
    task automatic applyStimulus(input logic [15:0] inVal, input logic [2:0] opVal, input logic [3:0] cntVal);
        @(negedge clk);
        sq.start = 1'b1;
        sq.in    = inVal;
        sq.op    = opVal;
        sq.cnt   = cntVal;
        @(negedge clk);
        sq.start = 1'b0;
    endtask

    task automatic waitDone(input int maxCycles, output int cycles, output int busyCycles);
        cycles     = 0;
        busyCycles = 0;
        while (sq.done !== 1'b1 && cycles <= maxCycles) begin
            if (sq.busy === 1'b1) busyCycles++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic ackResult();
        @(negedge clk);
        sq.ack = 1'b1;
        @(negedge clk);
        sq.ack = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        compared++;
        if (sq.busy !== 1'b0 || sq.done !== 1'b0 || sq.err !== 1'b0 || sq.result !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL reset_state: busy=%b done=%b err=%b result=%h, required 0/0/0/0000",
                     sq.busy, sq.done, sq.err, sq.result);
        end
        rst = 1'b0;
    endtask

    task automatic test_rotate_hold_ack();
        int cycles, busyCycles;
        applyStimulus(16'h8001, 3'b000, 4'd4);
        waitDone(40, cycles, busyCycles);
        compared++;
        if (cycles !== 5) begin
            mismatched++;
            $display("[TB] FAIL rol_latency: got %0d edges, required 5", cycles);
        end
        compared++;
        if (busyCycles !== 5) begin
            mismatched++;
            $display("[TB] FAIL rol_busy_cycles: got %0d, required 5", busyCycles);
        end
        compared++;
        if (sq.result !== 16'h0018 || sq.err !== 1'b0 || sq.busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rol_result: result=%h err=%b busy=%b, required 0018/0/0", sq.result, sq.err, sq.busy);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if (sq.done !== 1'b1 || sq.result !== 16'h0018 || sq.err !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL hold_stable[%0d]: done=%b result=%h err=%b, required 1/0018/0",
                         i, sq.done, sq.result, sq.err);
            end
        end
        ackResult();
        compared++;
        if (sq.done !== 1'b0 || sq.busy !== 1'b0 || sq.result !== 16'h0018) begin
            mismatched++;
            $display("[TB] FAIL ack_to_idle: done=%b busy=%b result=%h, required 0/0/0018", sq.done, sq.busy, sq.result);
        end
    endtask

    task automatic test_ops();
        logic [15:0] vecIn  [8] = '{16'h8000, 16'h8000, 16'h00FF, 16'h0001, 16'h8001, 16'h0003, 16'h0001, 16'h7FFF};
        logic [2:0]  vecOp  [8] = '{3'b011, 3'b100, 3'b010, 3'b001, 3'b011, 3'b010, 3'b000, 3'b100};
        logic [3:0]  vecCnt [8] = '{4'd3, 4'd15, 4'd8, 4'd1, 4'd15, 4'd15, 4'd15, 4'd15};
        logic [15:0] vecExp [8] = '{16'hF000, 16'h0001, 16'hFF00, 16'h8000, 16'hFFFF, 16'h8000, 16'h8000, 16'h0000};
        int cycles, busyCycles;
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecIn[v], vecOp[v], vecCnt[v]);
            waitDone(40, cycles, busyCycles);
            compared++;
            if (cycles !== int'(vecCnt[v]) + 1 || sq.result !== vecExp[v] || sq.err !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL op_vector[%0d]: edges=%0d result=%h err=%b, required %0d/%h/0",
                         v, cycles, sq.result, sq.err, int'(vecCnt[v]) + 1, vecExp[v]);
            end
            ackResult();
        end
    endtask

    task automatic test_zero_count_and_illegal();
        int cycles, busyCycles;
        applyStimulus(16'h00FF, 3'b010, 4'd0);
        waitDone(40, cycles, busyCycles);
        compared++;
        if (cycles !== 1 || sq.result !== 16'h00FF) begin
            mismatched++;
            $display("[TB] FAIL zero_count: edges=%0d result=%h, required 1/00ff", cycles, sq.result);
        end
        ackResult();

        applyStimulus(16'h1234, 3'b110, 4'd5);
        waitDone(40, cycles, busyCycles);
        compared++;
        if (cycles !== 0 || busyCycles !== 0 || sq.err !== 1'b1 || sq.result !== 16'h1234) begin
            mismatched++;
            $display("[TB] FAIL illegal_op: edges=%0d busy=%0d err=%b result=%h, required 0/0/1/1234",
                     cycles, busyCycles, sq.err, sq.result);
        end
        ackResult();
        compared++;
        if (sq.err !== 1'b0 || sq.done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL illegal_ack_clear: err=%b done=%b, required 0/0", sq.err, sq.done);
        end

        applyStimulus(16'h0001, 3'b000, 4'd1);
        waitDone(40, cycles, busyCycles);
        compared++;
        if (cycles !== 2 || sq.err !== 1'b0 || sq.result !== 16'h0002) begin
            mismatched++;
            $display("[TB] FAIL legal_after_illegal: edges=%0d err=%b result=%h, required 2/0/0002", cycles, sq.err, sq.result);
        end
        ackResult();
    endtask

    task automatic test_ignore_during_shift();
        int cycles, busyCycles;
        applyStimulus(16'h0005, 3'b010, 4'd3);
        sq.start = 1'b1;
        sq.in    = 16'hFFFF;
        sq.op    = 3'b100;
        sq.cnt   = 4'd15;
        @(negedge clk);
        sq.start = 1'b0;
        waitDone(40, cycles, busyCycles);
        compared++;
        if (cycles + 1 !== 4 || sq.result !== 16'h0028 || sq.err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ignore_in_shift: edges=%0d result=%h err=%b, required 4/0028/0", cycles + 1, sq.result, sq.err);
        end
        ackResult();
    endtask

    task automatic test_back_to_back();
        int cycles, busyCycles;
        applyStimulus(16'h0001, 3'b000, 4'd2);
        waitDone(40, cycles, busyCycles);
        compared++;
        if (sq.result !== 16'h0004) begin
            mismatched++;
            $display("[TB] FAIL b2b_first: result=%h, required 0004", sq.result);
        end
        @(negedge clk);
        sq.ack   = 1'b1;
        sq.start = 1'b1;
        sq.in    = 16'h0003;
        sq.op    = 3'b000;
        sq.cnt   = 4'd2;
        @(negedge clk);
        sq.ack   = 1'b0;
        sq.start = 1'b0;
        compared++;
        if (sq.done !== 1'b0 || sq.busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_done_drop: done=%b busy=%b, required 0/1", sq.done, sq.busy);
        end
        waitDone(40, cycles, busyCycles);
        compared++;
        if (cycles !== 3 || sq.result !== 16'h000C) begin
            mismatched++;
            $display("[TB] FAIL b2b_second: edges=%0d result=%h, required 3/000c", cycles, sq.result);
        end
        ackResult();
    endtask

    task automatic test_async_reset();
        int cycles, busyCycles;
        applyStimulus(16'h8001, 3'b011, 4'd10);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if (sq.busy !== 1'b0 || sq.done !== 1'b0 || sq.err !== 1'b0 || sq.result !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL async_reset: busy=%b done=%b err=%b result=%h, required 0/0/0/0000",
                     sq.busy, sq.done, sq.err, sq.result);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (sq.busy !== 1'b0 || sq.done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_abandons: busy=%b done=%b, required 0/0", sq.busy, sq.done);
        end
        applyStimulus(16'h0003, 3'b000, 4'd2);
        waitDone(40, cycles, busyCycles);
        compared++;
        if (cycles !== 3 || sq.result !== 16'h000C || sq.err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL after_reset_run: edges=%0d result=%h err=%b, required 3/000c/0", cycles, sq.result, sq.err);
        end
        ackResult();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        sq.start   = 1'b0;
        sq.in      = 16'h0000;
        sq.op      = 3'b000;
        sq.cnt     = 4'd0;
        sq.ack     = 1'b0;

        test_reset();
        test_rotate_hold_ack();
        test_ops();
        test_zero_count_and_illegal();
        test_ignore_during_shift();
        test_back_to_back();
        test_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-bit shift sequencer for the 16-bit datapath. It accepts one shift request (operand, op, count) and applies one single-bit shift or rotate per clock, count times.
- It holds the result with a done flag until the consumer acknowledges it.
- Used by the execute stage for shift/rotate instructions whose amount exceeds one bit, in place of a full barrel shifter.

Parameters:
- WIDTH, 16, operand/result width in bits.
- CNT_W, 4, width of the shift-count input (maximum count 2^CNT_W-1 = 15).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only when the block can accept.
- in  input  WIDTH  operand.
- op  input  3  shift operation code.
- cnt  input  CNT_W  number of single-bit steps.
- ack  input  1  consumer has taken the result.
- busy  output  1  high in SHIFT state.
- done  output  1  high in DONE state; result/err valid.
- err  output  1  illegal op flag; valid while done.
- result  output  WIDTH  shifted value; valid only while done.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, err=0, result=0, internal remaining counter=0.
  - Reset mid-SHIFT or mid-DONE abandons the operation; no done is produced for it.
- One-step transform f(op, x):
  - 000: rotate left, {x[14:0],x[15]}.
  - 001: rotate right, {x[0],x[15:1]}.
  - 010: shift left logical, {x[14:0],0}.
  - 011: shift right arithmetic, {x[15],x[15:1]}.
  - 100: shift right logical, {0,x[15:1]}.
  - 101-111: illegal.
- States: IDLE, SHIFT, DONE. busy and done are registered decodes of the state.
- IDLE:
  - start=1 with legal op: capture result<=in, op_r<=op, remaining<=cnt; go to SHIFT.
  - start=1 with illegal op: result<=in, err<=1; go directly to DONE.
  - start=0: stay in IDLE.
- SHIFT:
  - remaining!=0: result<=f(op_r,result), remaining<=remaining-1; stay in SHIFT.
  - remaining==0: go to DONE, err<=0; result unchanged.
  - start is ignored in SHIFT. Inputs in/op/cnt are not re-sampled.
- Latency (legal op): start accepted at edge k; done first high after edge k+cnt+1.
  - cnt=0 gives done after edge k+1 with result=in.
  - Illegal op: done after edge k.
- DONE:
  - result, err and done are held stable while ack=0.
  - ack=1, start=0: go to IDLE; err<=0; result holds its value.
  - ack=1, start=1: back-to-back. Treat as IDLE acceptance of the new request in the same edge (capture and go to SHIFT, or to DONE for an illegal op). done drops for at least one cycle on the legal path.
  - ack=0, start=1: start is ignored.
- ack outside DONE is ignored.
- Count is a plain step count with no modulo or wrap. Rotations by 15 are legal.
- Shifts by 15 produce:
  - SLL: x[0]<<15.
  - SRL: x[15].
  - SRA: sign replicated across all bits.
- op_r is held from capture so that op changes during SHIFT have no effect.

Test Plan:
- Reset, then start with in=16'h8001, op=000, cnt=4 -> busy for 5 cycles; done after edge k+5; result=16'h0018, err=0. Hold ack=0 for 3 cycles -> outputs stable. ack=1 -> IDLE next edge, done=0.
- op=011, in=16'h8000, cnt=3 -> result=16'hF000. Then op=100, in=16'h8000, cnt=15 -> result=16'h0001. Then op=010, in=16'h00FF, cnt=8 -> result=16'hFF00. Then op=001, in=16'h0001, cnt=1 -> result=16'h8000.
- op=010, in=16'h00FF, cnt=0 -> done after edge k+1, result=16'h00FF. op=110, in=16'h1234 -> done after edge k, err=1, result=16'h1234. Following legal op -> err=0.
- During SHIFT, assert start with in=16'hFFFF, op=100 and change the op input -> ignored; original result unaffected.
- In DONE, assert ack=1 and start=1 together (in=16'h0003, op=000, cnt=2) -> next request runs; done after 3 more edges; result=16'h000C.
- Assert rst asynchronously mid-SHIFT (between clock edges) -> busy=0, done=0, err=0, result=0 immediately. After release, a new request completes normally.
